// File: rtl/pixel_scanout_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pixel_scanout_pkg
// Description : 640x480@60 VGA timing and 160x120 frame-buffer constants.
// Revision    : 1.0 - initial release
// ============================================================================
package pixel_scanout_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int FB_W     = 160;
    localparam int FB_H     = 120;
    localparam int FB_DEPTH = FB_W * FB_H;

    typedef logic [2:0] colour_t;

    // y*160 + x without a multiplier.
    function automatic logic [14:0] fb_addr(input logic [7:0] x, input logic [6:0] y);
        fb_addr = {1'b0, y, 7'b0} + {3'b0, y, 5'b0} + {7'b0, x};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_scanout_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Pixel-enable, h/v counters, raw syncs/blank and frame tick.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import pixel_scanout_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    output logic       o_pix_en,
    output logic [7:0] o_scan_x,
    output logic [6:0] o_scan_y,
    output logic       o_hs,
    output logic       o_vs,
    output logic       o_active,
    output logic       o_frame_start
);

    localparam logic [9:0] c_H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] c_V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] c_V_ACT_END = 10'(V_ACTIVE - 1);

    logic       r_pix_en;
    logic [9:0] r_h;
    logic [9:0] r_v;
    logic       r_frame_start;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_pix_en      <= 1'b0;
            r_h           <= '0;
            r_v           <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_pix_en      <= ~r_pix_en;
            r_frame_start <= 1'b0;
            if (r_pix_en) begin
                if (r_h == c_H_LAST) begin
                    r_h <= '0;
                    r_v <= (r_v == c_V_LAST) ? 10'd0 : r_v + 10'd1;
                    // Lands on the first clk of v=480, h=0.
                    if (r_v == c_V_ACT_END)
                        r_frame_start <= 1'b1;
                end else begin
                    r_h <= r_h + 10'd1;
                end
            end
        end
    end

    assign o_pix_en      = r_pix_en;
    assign o_scan_x      = r_h[9:2];
    assign o_scan_y      = r_v[8:2];
    assign o_hs          = !((r_h >= 10'(H_ACTIVE + H_FP)) && (r_h < 10'(H_ACTIVE + H_FP + H_SYNC)));
    assign o_vs          = !((r_v >= 10'(V_ACTIVE + V_FP)) && (r_v < 10'(V_ACTIVE + V_FP + V_SYNC)));
    assign o_active      = (r_h < 10'(H_ACTIVE)) && (r_v < 10'(V_ACTIVE));
    assign o_frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: rtl/pixel_scanout.sv
`default_nettype none
// ============================================================================
// Module      : pixel_scanout
// Description : 160x120x3 frame buffer with clear engine and plot port,
//               scanned out as 640x480@60 VGA with 4x4 pixel replication.
//               SCANOUT_TEST_PATTERN_EN adds a colour-bar test_pattern input.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_scanout
    import pixel_scanout_pkg::*;
#(
    parameter int                  COLOUR_W  = 3,
    parameter logic [COLOUR_W-1:0] BG_COLOUR = 3'b000
) (
    input  logic                clk,
    input  logic                resetn,
`ifdef SCANOUT_TEST_PATTERN_EN
    input  logic                test_pattern,
`endif
    input  logic [7:0]          plot_x,
    input  logic [6:0]          plot_y,
    input  logic [COLOUR_W-1:0] plot_colour,
    input  logic                plot_valid,
    output logic                plot_ready,
    input  logic                clear_req,
    output logic                frame_start,
    output logic [7:0]          vga_r,
    output logic [7:0]          vga_g,
    output logic [7:0]          vga_b,
    output logic                vga_hs,
    output logic                vga_vs,
    output logic                vga_blank_n,
    output logic                vga_sync_n,
    output logic                vga_clk
);

    localparam logic [0:0]  S_CLEAR   = 1'b0;
    localparam logic [0:0]  S_IDLE    = 1'b1;
    localparam logic [14:0] c_FB_LAST = 15'(FB_DEPTH - 1);

    logic                w_pix_en;
    logic [7:0]          w_scan_x;
    logic [6:0]          w_scan_y;
    logic                w_hs_raw;
    logic                w_vs_raw;
    logic                w_active;

    vga_timing_gen u_timing (
        .clk           (clk),
        .resetn        (resetn),
        .o_pix_en      (w_pix_en),
        .o_scan_x      (w_scan_x),
        .o_scan_y      (w_scan_y),
        .o_hs          (w_hs_raw),
        .o_vs          (w_vs_raw),
        .o_active      (w_active),
        .o_frame_start (frame_start)
    );

    logic [0:0]          r_state;
    logic [14:0]         r_clr_addr;
    logic                r_plot_ready;

    // clear_req restarts from address 0 regardless of state.
    always_ff @(posedge clk) begin
        if (!resetn || clear_req) begin
            r_state      <= S_CLEAR;
            r_clr_addr   <= '0;
            r_plot_ready <= 1'b0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    if (r_clr_addr == c_FB_LAST) begin
                        r_state      <= S_IDLE;
                        r_plot_ready <= 1'b1;
                    end else begin
                        r_clr_addr <= r_clr_addr + 15'd1;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_plot_ready <= 1'b1;
                end
            endcase
        end
    end

    logic                w_in_range;
    logic                w_clr_we;
    logic                w_plot_we;
    logic                w_we;
    logic [14:0]         w_wr_addr;
    logic [COLOUR_W-1:0] w_wr_data;
    logic [14:0]         w_rd_addr;

    assign w_in_range = (plot_x < 8'(FB_W)) && (plot_y < 7'(FB_H));
    assign w_clr_we   = (r_state == S_CLEAR);
    assign w_plot_we  = (r_state == S_IDLE) && plot_valid && !clear_req && w_in_range;
    assign w_we       = w_clr_we || w_plot_we;
    assign w_wr_addr  = w_clr_we ? r_clr_addr : fb_addr(plot_x, plot_y);
    assign w_wr_data  = w_clr_we ? BG_COLOUR : plot_colour;
    assign w_rd_addr  = w_active ? fb_addr(w_scan_x, w_scan_y) : 15'd0;

    logic [COLOUR_W-1:0] r_fb [FB_DEPTH];
    logic [COLOUR_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (w_we)
            r_fb[w_wr_addr] <= w_wr_data;
    end

    always_ff @(posedge clk) begin
        if (w_pix_en)
            r_rd_data <= r_fb[w_rd_addr];
    end

    logic                r_hs;
    logic                r_vs;
    logic                r_blank_n;
    logic [COLOUR_W-1:0] w_colour;

    // Sync/blank share the read stage so they stay aligned with rgb.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_hs      <= 1'b1;
            r_vs      <= 1'b1;
            r_blank_n <= 1'b0;
        end else if (w_pix_en) begin
            r_hs      <= w_hs_raw;
            r_vs      <= w_vs_raw;
            r_blank_n <= w_active;
        end
    end

`ifdef SCANOUT_TEST_PATTERN_EN
    logic    r_tp_sel;
    colour_t r_bar;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_tp_sel <= 1'b0;
            r_bar    <= '0;
        end else if (w_pix_en) begin
            r_tp_sel <= test_pattern;
            r_bar    <= w_scan_x[7:5];
        end
    end

    assign w_colour = r_tp_sel ? COLOUR_W'(r_bar) : r_rd_data;
`else
    assign w_colour = r_rd_data;
`endif

    assign vga_r       = r_blank_n ? {8{w_colour[2]}} : 8'h00;
    assign vga_g       = r_blank_n ? {8{w_colour[1]}} : 8'h00;
    assign vga_b       = r_blank_n ? {8{w_colour[0]}} : 8'h00;
    assign vga_hs      = r_hs;
    assign vga_vs      = r_vs;
    assign vga_blank_n = r_blank_n;
    assign vga_sync_n  = 1'b0;
    assign vga_clk     = w_pix_en;
    assign plot_ready  = r_plot_ready;

endmodule
`default_nettype wire

// File: tb/tb_pixel_scanout.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_scanout
// Description : Randomised plot/clear stimulus checked per clock against a
//               frame-buffer array and VGA timing arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_scanout;

    localparam logic [2:0] BG       = 3'b000;
    localparam int         CLR_LEN  = 19200;
    localparam int         LINE_CLK = 1600;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] plot_x = '0;
    logic [6:0] plot_y = '0;
    logic [2:0] plot_colour = '0;
    logic       plot_valid = 1'b0;
    logic       plot_ready;
    logic       clear_req = 1'b0;
    logic       frame_start;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk;

    always #10 clk = ~clk;

    pixel_scanout #(.COLOUR_W(3), .BG_COLOUR(BG)) dut (
        .clk         (clk),
        .resetn      (resetn),
`ifdef SCANOUT_TEST_PATTERN_EN
        .test_pattern(1'b0),
`endif
        .plot_x      (plot_x),
        .plot_y      (plot_y),
        .plot_colour (plot_colour),
        .plot_valid  (plot_valid),
        .plot_ready  (plot_ready),
        .clear_req   (clear_req),
        .frame_start (frame_start),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_blank_n (vga_blank_n),
        .vga_sync_n  (vga_sync_n),
        .vga_clk     (vga_clk)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;
    int clr_s = 0;
    int clr_e = CLR_LEN;
    logic mon_en = 1'b0;
    logic chk_px = 1'b0;
    logic [2:0] model [0:119][0:159];

    always @(posedge clk) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [23:0] expand(input logic [2:0] c);
        return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
    endfunction

    task automatic model_clear();
        for (int y = 0; y < 120; y++)
            for (int x = 0; x < 160; x++)
                model[y][x] = BG;
    endtask

    task automatic drive_plot(input int x, input int y, input logic [2:0] col);
        plot_x      = 8'(x);
        plot_y      = 7'(y);
        plot_colour = col;
        plot_valid  = 1'b1;
        check_eq("plot_handshake", 32'(plot_ready), 32'd1);
        if (x < 160 && y < 120) model[y][x] = col;
        @(negedge clk);
    endtask

    // A clear requested in cycle c holds plot_ready low for [c+1, c+1+19200).
    task automatic pulse_clear();
        if (cyc + 1 <= clr_e) begin
            clr_e = cyc + 1 + CLR_LEN;
        end else begin
            clr_s = cyc + 1;
            clr_e = cyc + 1 + CLR_LEN;
        end
        clear_req = 1'b1;
        model_clear();
    endtask

    task automatic random_plots(input int count, input int y_lo, input int y_hi, input int x_lo);
        int x, y;
        for (int i = 0; i < count; i++) begin
            if ($urandom_range(3) == 0) begin
                plot_valid = 1'b0;
                @(negedge clk);
            end
            x = int'($urandom_range(159, x_lo));
            y = int'($urandom_range(y_hi, y_lo));
            if ($urandom_range(4) == 0) x = int'($urandom_range(255, 160));
            drive_plot(x, y, 3'($urandom_range(7)));
        end
        plot_valid = 1'b0;
    endtask

    // Output n = cyc/2-1 is the pixel read at the previous pix_en edge.
    always @(negedge clk) begin : monitor
        int n, h, v;
        logic act, e_hs, e_vs, e_rdy, e_fs;
        if (mon_en) begin
            n = cyc / 2 - 1;
            if (n < 0) begin
                h = 0; v = 0; act = 1'b0; e_hs = 1'b1; e_vs = 1'b1;
            end else begin
                h    = n % 800;
                v    = (n / 800) % 525;
                act  = (h < 640) && (v < 480);
                e_hs = !(h >= 656 && h <= 751);
                e_vs = !(v >= 490 && v <= 491);
            end
            e_rdy = !(cyc >= clr_s && cyc < clr_e);
            e_fs  = ((cyc % 840000) == 480 * LINE_CLK);
            check_eq("vga_hs", 32'(vga_hs), 32'(e_hs));
            check_eq("vga_vs", 32'(vga_vs), 32'(e_vs));
            check_eq("vga_blank_n", 32'(vga_blank_n), 32'(act));
            check_eq("vga_clk", 32'(vga_clk), 32'(cyc % 2));
            check_eq("vga_sync_n", 32'(vga_sync_n), 32'd0);
            check_eq("frame_start", 32'(frame_start), 32'(e_fs));
            check_eq("plot_ready", 32'(plot_ready), 32'(e_rdy));
            if (!act)
                check_eq("rgb_blank", 32'({vga_r, vga_g, vga_b}), 32'd0);
            else if (chk_px)
                check_eq("rgb_pixel", 32'({vga_r, vga_g, vga_b}), 32'(expand(model[v / 4][h / 4])));
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (4) @(negedge clk);
        check_eq("rst_plot_ready", 32'(plot_ready), 32'd0);
        check_eq("rst_hs", 32'(vga_hs), 32'd1);
        check_eq("rst_vs", 32'(vga_vs), 32'd1);
        check_eq("rst_blank_n", 32'(vga_blank_n), 32'd0);
        check_eq("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
        check_eq("rst_frame_start", 32'(frame_start), 32'd0);
        check_eq("rst_vga_clk", 32'(vga_clk), 32'd0);
        model_clear();
        resetn = 1'b1;
        mon_en = 1'b1;

        // Plots into rows 4-5 (scanned on lines 16-23) and rows 10-11.
        while (cyc < CLR_LEN + 5) @(negedge clk);
        random_plots(40, 4, 5, 20);
        drive_plot(10, 5, 3'b100);
        drive_plot(160, 4, 3'b111);
        drive_plot(160, 5, 3'b111);
        drive_plot(3, 120, 3'b111);
        drive_plot(10, 10, 3'b010);
        plot_valid = 1'b0;
        random_plots(12, 10, 11, 0);
        chk_px = 1'b1;

        // Clear with a same-cycle plot, then restart it 5000 clk in.
        while (cyc < 24 * LINE_CLK) @(negedge clk);
        chk_px = 1'b0;
        drive_plot_with_clear();
        while (cyc < 24 * LINE_CLK + 5000) @(negedge clk);
        pulse_clear();
        @(negedge clk);
        clear_req = 1'b0;
        while (cyc < clr_e) @(negedge clk);
        check_eq("clear_done_ready", 32'(plot_ready), 32'd1);

        // Rows 10-11 must now show only what is plotted after the clear.
        chk_px = 1'b1;
        random_plots(20, 10, 11, 0);
        drive_plot(12, 10, 3'b001);
        plot_valid = 1'b0;
        while (cyc < 48 * LINE_CLK + 100) @(negedge clk);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    task automatic drive_plot_with_clear();
        plot_x      = 8'd50;
        plot_y      = 7'd11;
        plot_colour = 3'b111;
        plot_valid  = 1'b1;
        check_eq("plot_vs_clear_ready", 32'(plot_ready), 32'd1);
        pulse_clear();
        @(negedge clk);
        clear_req  = 1'b0;
        plot_valid = 1'b0;
    endtask

endmodule
`default_nettype wire
